soc_system_instruction_queue: RTL and testbench
===============================================

// Module: soc_system_instruction_queue
// PURPOSE
//  Avalon-MM slave, parametrised successor to the single-register instruction PIO.
//  The HPS writes instruction words into a DEPTH-entry FIFO instead of overwriting one output register.
//  The FIFO issues those words to fabric logic over a valid/ready stream.
//  Status, control and an issued-instruction counter are readable over the same slave; sits between HPS-FPGA bridge and accelerator.
// PARAMETERS
//  DATA_W  11  instruction word width (1..32)
//  DEPTH   8   FIFO entries; power of two, >=2
//  CNT_W   16  issued-instruction counter width (1..32)
// PORTS
//  clk         in   1       system clock
//  reset_n     in   1       asynchronous active-low reset
//  address     in   2       register select
//  chipselect  in   1       slave select
//  write_n     in   1       active-low write strobe
//  writedata   in   32      write data
//  readdata    out  32      read data, combinational, zero wait-state
//  out_data    out  DATA_W  FIFO head word
//  out_valid   out  1       head word valid
//  out_ready   in   1       downstream accepts head word
// BEHAVIOUR
//  Interface: one clock (clk); reset_n asynchronous, active-low. All state clears on reset assertion.
//  Write strobe: wr = chipselect & ~write_n. Reads have no side effects.
//  Register map, unused readdata bits 0:
//   0 DATA   wr: push writedata[DATA_W-1:0]; rd: last word pushed (reset 0)
//   1 STATUS rd: [LVL_W-1:0] level, [16] empty, [17] full, [18] overflow (sticky); wr bit18=1 clears overflow
//   2 CONTROL [0] enable (reset 1), [1] flush (write-1 pulse, reads 0), [2] irq_mask (IRQ build only, reset 0)
//   3 ISSUED rd: issued counter, zero-extended; any write clears it
//  LVL_W = $clog2(DEPTH)+1.
//  Push rules:
//   - Push accepted when not full; level updates the next cycle.
//   - Push while full is dropped and sets overflow, even if a pop occurs the same cycle.
//  out_valid = enable & ~empty; out_data = head word (show-ahead); out_data is 0 when empty.
//  Pop occurs on out_valid & out_ready; it advances the read pointer and increments ISSUED (wraps 2^CNT_W-1 -> 0).
//  Latency: DATA write in cycle N into an empty FIFO -> out_valid high in cycle N+1.
//  Simultaneous push+pop when not full: level unchanged, both take effect.
//  enable=0: out_valid held 0; pushes are still accepted; the head word is held.
//  Flush:
//   - Empties the FIFO next cycle; pointers return to 0.
//   - A push in the same write cycle is impossible (single address); a pop in the same cycle is suppressed.
//   - overflow and ISSUED are untouched.
//  ISSUED clear coincident with a pop: clear wins, value 0.
//  Pointer wrap is by natural overflow of the $clog2(DEPTH) index; full = level==DEPTH.
//  Reset asserted mid-transfer: out_valid drops immediately (async); queued words are lost.
// CONFIGURATION
//  Macro SOC_INSTR_QUEUE_IRQ_EN.
//  Defined:
//   - Adds port irq (out, 1).
//   - irq = irq_mask & empty & (ISSUED != 0), registered: asserts the cycle after the FIFO drains.
//   - irq deasserts on the next push, on ISSUED clear, or when the mask is cleared. Reset value 0.
//  Undefined: no irq port; CONTROL[2] reads 0 and ignores writes.
// STRUCTURE
//  Package soc_instr_queue_pkg:
//   - register address localparams (ADDR_DATA/STATUS/CONTROL/ISSUED);
//   - STATUS and CONTROL bit-position constants.
//  Sub-module soc_instr_sync_fifo (DATA_W, DEPTH): push/pop/flush, head, level, full, empty.
//  Top holds the register decode, counter, sticky flag and optional irq.
// TESTING
//  T1 reset, then read addr1 -> level 0, empty=1, full=0; out_valid=0; addr2 reads 0x1.
//  T2 write 0x5A5 to addr0, out_ready=0:
//   - out_valid=1 next cycle, out_data=0x5A5;
//   - pulse out_ready -> empty=1, ISSUED=1.
//  T3 out_ready=0, push 9 words (0x001..0x009) with DEPTH=8:
//   - full=1, overflow=1, 0x009 dropped;
//   - drain -> 0x001..0x008 in order, ISSUED=8.
//  T4 FIFO full with out_ready=1 and push on the same cycle:
//   - push dropped, overflow set;
//   - level=7 next cycle.
//  T5 enable=0 with 3 words queued: out_valid stays 0 while out_ready=1. Then write flush: level=0, ISSUED unchanged.
//  T6 (IRQ build) irq_mask=1, push 1 word, pop it:
//   - irq=1 the cycle after the pop;
//   - write addr3 -> ISSUED=0, irq=0.

Source files
------------

// File: rtl/soc_system_instruction_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package  : soc_instr_queue_pkg
// Brief    : Register map and bit positions shared by the instruction queue
//            slave and its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package soc_instr_queue_pkg;

  // Avalon-MM register addresses
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_ISSUED  = 2'd3;

  // STATUS bit positions (level occupies the low LVL_W bits)
  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;

  // CONTROL bit positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_IRQM_BIT  = 2;

  // Level width for a FIFO of the given depth: index bits plus one
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : soc_instr_queue_pkg
`default_nettype wire

// File: rtl/soc_system_instruction_queue_if.sv
`default_nettype none
// ============================================================================
// Interface : soc_instr_queue_if
// Brief     : Avalon-MM slave bus plus the instruction valid/ready stream.
//             'slave' is the queue side, 'master' is the HPS/fabric side.
// Revision  : 1.0 - initial release
// ============================================================================
interface soc_instr_queue_if #(
  parameter int DATA_W = 11
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_data, out_valid
  );

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_data, out_valid
  );
endinterface : soc_instr_queue_if
`default_nettype wire

// File: rtl/soc_system_instruction_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : soc_instr_sync_fifo
// Brief    : Single-clock show-ahead FIFO with flush. Head reads 0 when
//            empty. Pointers wrap naturally; full is level == DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module soc_instr_sync_fifo
  import soc_instr_queue_pkg::*;
#(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = lvl_width(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              i_push,
  input  wire logic [DATA_W-1:0] i_push_data,
  input  wire logic              i_pop,
  input  wire logic              i_flush,
  output logic [DATA_W-1:0]      o_head,
  output logic [LVL_W-1:0]       o_level,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_empty_nxt
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;

  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [LVL_W-1:0]  w_level_nxt;

  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_empty   = (r_level == '0);
  // A push while full is dropped even if a pop frees a slot this cycle
  assign w_push_ok = i_push & ~w_full & ~i_flush;
  assign w_pop_ok  = i_pop & ~w_empty & ~i_flush;

  // Next occupancy; flush overrides any concurrent traffic
  always_comb begin
    w_level_nxt = r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop_ok);
    if (i_flush) begin
      w_level_nxt = '0;
    end
  end

  // Storage array write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  // Pointers and level; flush returns both pointers to 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_level <= w_level_nxt;
      if (i_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

  assign o_head      = w_empty ? '0 : r_mem[r_rptr];
  assign o_level     = r_level;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_empty_nxt = (w_level_nxt == '0);

endmodule : soc_instr_sync_fifo
`default_nettype wire

// File: rtl/soc_system_instruction_queue.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_instruction_queue
// Brief    : Avalon-MM instruction queue. HPS writes words into a FIFO that
//            issues them over valid/ready; STATUS/CONTROL/ISSUED are readable.
//            Optional build macro SOC_INSTR_QUEUE_IRQ_EN adds the irq output
//            and the CONTROL irq_mask bit.
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_instruction_queue
  import soc_instr_queue_pkg::*;
#(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  soc_instr_queue_if.slave   bus
`ifdef SOC_INSTR_QUEUE_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int LVL_W = lvl_width(DEPTH);

  logic              w_wr;
  logic              w_push;
  logic              w_flush;
  logic              w_pop;
  logic              w_ovf_clr;
  logic              w_cnt_clr;
  logic              w_ctrl_wr;

  logic [DATA_W-1:0] w_head;
  logic [LVL_W-1:0]  w_level;
  logic              w_full;
  logic              w_empty;
  logic              w_empty_nxt;
  logic [CNT_W-1:0]  w_issued_nxt;
  logic [31:0]       w_rdata;

  logic [DATA_W-1:0] r_last;
  logic              r_enable;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_issued;

  // Bus decode: single address per cycle, so push and flush never coincide
  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_push    = w_wr & (bus.address == ADDR_DATA);
  assign w_ctrl_wr = w_wr & (bus.address == ADDR_CONTROL);
  assign w_flush   = w_ctrl_wr & bus.writedata[CTRL_FLUSH_BIT];
  assign w_ovf_clr = w_wr & (bus.address == ADDR_STATUS) & bus.writedata[STAT_OVF_BIT];
  assign w_cnt_clr = w_wr & (bus.address == ADDR_ISSUED);
  assign w_pop     = bus.out_valid & bus.out_ready & ~w_flush;

  soc_instr_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (bus.writedata[DATA_W-1:0]),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_head      (w_head),
    .o_level     (w_level),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_empty_nxt (w_empty_nxt)
  );

  assign bus.out_valid = r_enable & ~w_empty;
  assign bus.out_data  = w_head;

  // Counter clear beats a coincident pop
  assign w_issued_nxt = w_cnt_clr ? '0 :
                        w_pop     ? r_issued + CNT_W'(1) : r_issued;

  // Control/status registers: last accepted word, enable, sticky overflow, count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last   <= '0;
      r_enable <= 1'b1;
      r_ovf    <= 1'b0;
      r_issued <= '0;
    end else begin
      r_issued <= w_issued_nxt;
      if (w_push && !w_full) begin
        r_last <= bus.writedata[DATA_W-1:0];
      end
      if (w_ctrl_wr) begin
        r_enable <= bus.writedata[CTRL_EN_BIT];
      end
      if (w_push && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef SOC_INSTR_QUEUE_IRQ_EN
  logic r_irq_mask;
  logic r_irq;
  logic w_mask_nxt;
  logic w_unused;

  assign w_mask_nxt = w_ctrl_wr ? bus.writedata[CTRL_IRQM_BIT] : r_irq_mask;

  // Drain interrupt evaluated on next-state values so it rises with the
  // emptying edge and falls with the next push, count clear or unmask
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_mask <= w_mask_nxt;
      r_irq      <= w_mask_nxt & w_empty_nxt & (w_issued_nxt != '0);
    end
  end

  assign irq      = r_irq;
  assign w_unused = ^bus.writedata;
`else
  logic r_irq_mask;
  logic w_unused;

  assign r_irq_mask = 1'b0;
  assign w_unused   = ^{bus.writedata, w_empty_nxt};
`endif

  // Zero-wait-state read mux; reads have no side effects
  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_DATA: begin
        w_rdata[DATA_W-1:0] = r_last;
      end
      ADDR_STATUS: begin
        w_rdata[LVL_W-1:0]     = w_level;
        w_rdata[STAT_EMPTY_BIT] = w_empty;
        w_rdata[STAT_FULL_BIT]  = w_full;
        w_rdata[STAT_OVF_BIT]   = r_ovf;
      end
      ADDR_CONTROL: begin
        w_rdata[CTRL_EN_BIT]   = r_enable;
        w_rdata[CTRL_IRQM_BIT] = r_irq_mask;
      end
      default: begin
        w_rdata[CNT_W-1:0] = r_issued;
      end
    endcase
  end

  assign bus.readdata = w_rdata;

endmodule : soc_system_instruction_queue
`default_nettype wire

// File: tb/tb_soc_system_instruction_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_instruction_queue
// Brief    : Random bus/stream traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_system_instruction_queue;

  localparam int DATA_W = 11;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int NCYC   = 3000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  soc_instr_queue_if #(.DATA_W(DATA_W)) bus ();
`ifdef SOC_INSTR_QUEUE_IRQ_EN
  logic irq;
`endif

  soc_system_instruction_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef SOC_INSTR_QUEUE_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_last;
  bit                m_en;
  bit                m_ovf;
  bit                m_mask;
  bit                m_irq;
  int unsigned       m_issued;

  function automatic void model_reset();
    m_q.delete();
    m_last   = '0;
    m_en     = 1'b1;
    m_ovf    = 1'b0;
    m_mask   = 1'b0;
    m_irq    = 1'b0;
    m_issued = 0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      2'd0: v = 32'(m_last);
      2'd1: v = 32'(m_q.size()) | (32'(m_q.size() == 0) << 16)
              | (32'(m_q.size() == DEPTH) << 17) | (32'(m_ovf) << 18);
`ifdef SOC_INSTR_QUEUE_IRQ_EN
      2'd2: v = 32'(m_en) | (32'(m_mask) << 2);
`else
      2'd2: v = 32'(m_en);
`endif
      default: v = m_issued;
    endcase
    return v;
  endfunction

  // Apply what the coming clock edge does, from the current bus inputs
  function automatic void model_step(input logic cs, input logic wn, input logic [1:0] a,
                                     input logic [31:0] wd, input logic rdy);
    bit wr, push, flush, pop, full;
    wr    = cs && !wn;
    push  = wr && a == 2'd0;
    flush = wr && a == 2'd2 && wd[1];
    full  = (m_q.size() == DEPTH);
    pop   = m_en && m_q.size() > 0 && rdy && !flush;
    if (pop) begin
      void'(m_q.pop_front());
      m_issued = (m_issued + 1) % (1 << CNT_W);
    end
    if (push) begin
      if (full) m_ovf = 1'b1;
      else begin
        m_q.push_back(wd[DATA_W-1:0]);
        m_last = wd[DATA_W-1:0];
      end
    end
    if (flush) m_q.delete();
    if (wr && a == 2'd1 && wd[18]) m_ovf = 1'b0;
    if (wr && a == 2'd2) begin
      m_en = wd[0];
`ifdef SOC_INSTR_QUEUE_IRQ_EN
      m_mask = wd[2];
`endif
    end
    if (wr && a == 2'd3) m_issued = 0;
    m_irq = m_mask && m_q.size() == 0 && m_issued != 0;
  endfunction

  task automatic check_state(input bit check_rd);
    chk("out_valid", 32'(bus.out_valid), 32'(m_en && m_q.size() > 0));
    chk("out_data", 32'(bus.out_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    if (check_rd) chk("readdata", bus.readdata, exp_read(bus.address));
`ifdef SOC_INSTR_QUEUE_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  initial begin
    int r;
    bit slow_phase;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    bus.out_ready  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state of every register
    for (int a = 0; a < 4; a++) begin
      bus.address    = 2'(a);
      bus.chipselect = 1'b1;
      #1;
      check_state(1'b1);
    end
    chk("rst_status", bus.readdata & 32'h0007_000F, 32'd0); // addr3 issued
    bus.address = 2'd1;
    #1;
    chk("rst_status_empty", bus.readdata, 32'h0001_0000);
    bus.address = 2'd2;
    #1;
    chk("rst_control", bus.readdata, 32'h0000_0001);

    slow_phase = 1'b1;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      if (i % 64 == 0) slow_phase = ~slow_phase;

      if (i == NCYC / 2) begin
        // Asynchronous reset mid-traffic
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.out_ready  = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        model_reset();
        bus.address    = 2'd1;
        bus.chipselect = 1'b1;
        #1;
        check_state(1'b1);
        reset_n = 1'b1;
        continue;
      end

      r = $urandom_range(0, 99);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.writedata  = $urandom();
      if (r < 40) begin
        bus.address = 2'd0;
      end else if (r < 45) begin
        bus.address = 2'd1;
      end else if (r < 52) begin
        bus.address      = 2'd2;
        bus.writedata[0] = ($urandom_range(0, 3) != 0);
        bus.writedata[1] = ($urandom_range(0, 3) == 0);
      end else if (r < 54) begin
        bus.address = 2'd3;
      end else if (r < 95) begin
        bus.address    = 2'($urandom_range(0, 3));
        bus.write_n    = 1'b1;
        bus.chipselect = 1'($urandom_range(0, 1));
      end else begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
      end
      bus.out_ready = slow_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      #1;
      check_state(bus.write_n);
      model_step(bus.chipselect, bus.write_n, bus.address, bus.writedata, bus.out_ready);
    end

    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    #1;
    check_state(1'b1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_soc_system_instruction_queue
`default_nettype wire
